// File: rtl/mul_seq.sv
// rtl/mul_seq.sv - three-state multiply / accumulate / round sequencer owning the MR register and flags
module mul_seq #(
  parameter int SIZE = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ps_mul_req,
  output logic                mul_ready,
  input  logic [1:0]          ps_mul_op,
  input  logic                ps_mul_IbF,
  input  logic                ps_mul_rndPrdt,
  input  logic                ps_mul_sat,
  input  logic [SIZE-1:0]     xb_dtx,
  input  logic [SIZE-1:0]     xb_dty,
  output logic [2*SIZE-1:0]   mr_out,
  output logic                mul_done,
  output logic                mul_mn,
  output logic                mul_mv
);

  localparam int W = 2 * SIZE;
  localparam logic [W-1:0]    R_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]    R_MIN = {1'b1, {(W-1){1'b0}}};
  localparam logic [SIZE-1:0] H_MAX = {1'b0, {(SIZE-1){1'b1}}};
  localparam logic [SIZE-1:0] H_MIN = {1'b1, {(SIZE-1){1'b0}}};

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_MAC  = 2'b01;
  localparam logic [1:0] OP_MSUB = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  typedef enum logic [1:0] {IDLE, MUL, ACC} state_t;

  state_t state, state_nxt;

  logic [1:0]      op_q;
  logic            ibf_q, rnd_q, sat_q;
  logic [SIZE-1:0] x_q, y_q;
  logic [W-1:0]    p_q;
  logic            mul_ov_q;
  logic            accept;

  assign mul_ready = (state == IDLE);
  assign accept    = ps_mul_req & mul_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = MUL;
      MUL:     state_nxt = ACC;
      ACC:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q  <= '0;
      ibf_q <= 1'b0;
      rnd_q <= 1'b0;
      sat_q <= 1'b0;
      x_q   <= '0;
      y_q   <= '0;
    end else if (accept) begin
      op_q  <= ps_mul_op;
      ibf_q <= ps_mul_IbF;
      rnd_q <= ps_mul_rndPrdt;
      sat_q <= ps_mul_sat;
      x_q   <= xb_dtx;
      y_q   <= xb_dty;
    end
  end

  // Product stage; -1 x -1 in Q-format is the only product that cannot be represented after the shift
  logic signed [W-1:0] prod;
  logic [W-1:0]        p_nxt;
  logic                min_sq;

  assign prod   = $signed({{SIZE{x_q[SIZE-1]}}, x_q}) * $signed({{SIZE{y_q[SIZE-1]}}, y_q});
  assign min_sq = ibf_q && (x_q == H_MIN) && (y_q == H_MIN);

  always_comb begin
    p_nxt = ibf_q ? W'(prod <<< 1) : W'(prod);
    if (min_sq) p_nxt = R_MAX;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_q      <= '0;
      mul_ov_q <= 1'b0;
    end else if (state == MUL) begin
      p_q      <= p_nxt;
      mul_ov_q <= min_sq;
    end
  end

  logic [W-1:0]    r_raw, r_sat, r_fin;
  logic            add_ov, rnd_ov, round_up, do_rnd;
  logic [SIZE-1:0] h;

  always_comb begin
    r_raw  = p_q;
    add_ov = 1'b0;
    case (op_q)
      OP_MAC: begin
        r_raw  = mr_out + p_q;
        add_ov = (mr_out[W-1] == p_q[W-1]) && (r_raw[W-1] != mr_out[W-1]);
      end
      OP_MSUB: begin
        r_raw  = mr_out - p_q;
        add_ov = (mr_out[W-1] != p_q[W-1]) && (r_raw[W-1] != mr_out[W-1]);
      end
      default: r_raw = p_q;
    endcase
  end

  // Overflow direction follows the old MR sign: only a positive MR can overflow upward
  assign r_sat    = (add_ov && sat_q) ? (mr_out[W-1] ? R_MIN : R_MAX) : r_raw;
  assign h        = r_sat[W-1:SIZE];
  assign do_rnd   = rnd_q & ibf_q;
  assign round_up = r_sat[SIZE-1] & ((|r_sat[SIZE-2:0]) | r_sat[SIZE]);
  assign rnd_ov   = do_rnd & round_up & (h == H_MAX);

  always_comb begin
    r_fin = r_sat;
    if (do_rnd) begin
      if (rnd_ov) r_fin = {(sat_q ? H_MAX : H_MIN), {SIZE{1'b0}}};
      else        r_fin = {h + SIZE'(round_up), {SIZE{1'b0}}};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mr_out   <= '0;
      mul_mn   <= 1'b0;
      mul_mv   <= 1'b0;
      mul_done <= 1'b0;
    end else begin
      mul_done <= (state == ACC);
      if (state == ACC) begin
        if (op_q == OP_CLR) begin
          mr_out <= '0;
          mul_mn <= 1'b0;
          mul_mv <= 1'b0;
        end else begin
          mr_out <= r_fin;
          mul_mn <= r_fin[W-1];
          mul_mv <= mul_mv | mul_ov_q | add_ov | rnd_ov;
        end
      end
    end
  end

endmodule

// File: tb/tb_mul_seq.sv
// tb/tb_mul_seq.sv - scoreboard bench for mul_seq with a 64-bit arithmetic reference model
module tb_mul_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ps_mul_req = 1'b0;
  logic        mul_ready;
  logic [1:0]  ps_mul_op = 2'b00;
  logic        ps_mul_IbF = 1'b0;
  logic        ps_mul_rndPrdt = 1'b0;
  logic        ps_mul_sat = 1'b0;
  logic [15:0] xb_dtx = '0;
  logic [15:0] xb_dty = '0;
  logic [31:0] mr_out;
  logic        mul_done;
  logic        mul_mn;
  logic        mul_mv;

  mul_seq #(.SIZE(16)) dut (
    .clk(clk), .reset(reset), .ps_mul_req(ps_mul_req), .mul_ready(mul_ready),
    .ps_mul_op(ps_mul_op), .ps_mul_IbF(ps_mul_IbF), .ps_mul_rndPrdt(ps_mul_rndPrdt),
    .ps_mul_sat(ps_mul_sat), .xb_dtx(xb_dtx), .xb_dty(xb_dty), .mr_out(mr_out),
    .mul_done(mul_done), .mul_mn(mul_mn), .mul_mv(mul_mv)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] mr; logic mn; logic mv; } exp_t;
  exp_t sb[$];

  int passed = 0;
  int fails  = 0;
  int total  = 0;
  logic [31:0] m_mr = '0;
  logic        m_mv = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [1:0] op, input logic ibf, input logic rnd, input logic sat,
                       input logic [15:0] x, input logic [15:0] y);
    longint p, r, mrs;
    int hs;
    logic [31:0] r32;
    logic [15:0] frac;
    bit ov;
    exp_t e;
    ov = 0;
    if (op == 2'b11) begin
      m_mr = '0;
      m_mv = 1'b0;
    end else begin
      if (ibf && x == 16'h8000 && y == 16'h8000) begin
        p  = 64'sh7FFF_FFFF;
        ov = 1;
      end else begin
        p = longint'($signed(x)) * longint'($signed(y));
        if (ibf) p = p * 2;
      end
      mrs = longint'($signed(m_mr));
      r = (op == 2'b00) ? p : (op == 2'b01) ? mrs + p : mrs - p;
      if (r > 64'sd2147483647) begin
        ov = 1;
        r  = sat ? 64'sd2147483647 : r - 64'sd4294967296;
      end else if (r < -64'sd2147483648) begin
        ov = 1;
        r  = sat ? -64'sd2147483648 : r + 64'sd4294967296;
      end
      r32 = r[31:0];
      if (rnd && ibf) begin
        hs   = int'($signed(r32[31:16]));
        frac = r32[15:0];
        if (frac > 16'h8000 || (frac == 16'h8000 && hs[0])) hs++;
        if (hs > 32767) begin
          ov  = 1;
          r32 = sat ? 32'h7FFF_0000 : 32'h8000_0000;
        end else begin
          r32 = {hs[15:0], 16'h0000};
        end
      end
      m_mr = r32;
      m_mv = m_mv | ov;
    end
    e.mr = m_mr;
    e.mn = m_mr[31];
    e.mv = m_mv;
    sb.push_back(e);
  endtask

  // Called on a falling edge with the DUT idle; returns on the falling edge of T+3
  task automatic issue(input logic [1:0] op, input logic ibf, input logic rnd, input logic sat,
                       input logic [15:0] x, input logic [15:0] y, input bit hold);
    exp_t e;
    chk("ready_idle", mul_ready, 1);
    ps_mul_op = op; ps_mul_IbF = ibf; ps_mul_rndPrdt = rnd; ps_mul_sat = sat;
    xb_dtx = x; xb_dty = y; ps_mul_req = 1'b1;
    model(op, ibf, rnd, sat, x, y);
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      chk("ready_busy", mul_ready, 0);
      chk("done_early", mul_done, 0);
      if (hold) begin
        ps_mul_op = 2'($urandom_range(0, 3));
        ps_mul_IbF = 1'($urandom); ps_mul_rndPrdt = 1'($urandom); ps_mul_sat = 1'($urandom);
        xb_dtx = 16'($urandom); xb_dty = 16'($urandom);
      end else begin
        ps_mul_req = 1'b0;
      end
    end
    @(negedge clk);
    chk("done_pulse", mul_done, 1);
    chk("ready_back", mul_ready, 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("mr", mr_out, e.mr);
      chk("mn", mul_mn, e.mn);
      chk("mv", mul_mv, e.mv);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ready", mul_ready, 1);
    chk("rst_done", mul_done, 0);
    chk("rst_mr", mr_out, 0);
    chk("rst_mn", mul_mn, 0);
    chk("rst_mv", mul_mv, 0);
    reset = 1'b1;
    @(negedge clk);

    issue(2'b00, 1, 0, 0, 16'h4000, 16'h4000, 0);
    chk("frac_mul", mr_out, 32'h2000_0000);
    @(negedge clk);
    chk("done_one_cycle", mul_done, 0);

    issue(2'b00, 1, 1, 0, 16'h0003, 16'h4000, 0);
    chk("rnd_tie_odd", mr_out, 32'h0002_0000);
    issue(2'b00, 1, 1, 0, 16'h0001, 16'h4000, 0);
    chk("rnd_tie_even", mr_out, 32'h0000_0000);
    issue(2'b00, 1, 1, 0, 16'h0003, 16'h2001, 0);
    chk("rnd_up", mr_out, 32'h0001_0000);

    issue(2'b00, 1, 0, 0, 16'h8000, 16'h8000, 0);
    chk("min_sq", mr_out, 32'h7FFF_FFFF);
    chk("min_sq_mv", mul_mv, 1);
    issue(2'b11, 0, 0, 0, 16'h1111, 16'h2222, 0);
    chk("clr", mr_out, 0);
    chk("clr_mv", mul_mv, 0);

    issue(2'b00, 0, 0, 1, 16'h7FFF, 16'h7FFF, 0);
    chk("int_mul", mr_out, 32'h3FFF_0001);
    issue(2'b01, 0, 0, 1, 16'h7FFF, 16'h7FFF, 0);
    chk("mac_sat1", mr_out, 32'h7FFE_0002);
    issue(2'b01, 0, 0, 1, 16'h7FFF, 16'h7FFF, 0);
    chk("mac_sat2", mr_out, 32'h7FFF_FFFF);
    chk("mac_sat2_mv", mul_mv, 1);
    issue(2'b11, 0, 0, 0, 16'h0, 16'h0, 0);

    issue(2'b00, 0, 0, 0, 16'h7FFF, 16'h7FFF, 0);
    issue(2'b01, 0, 0, 0, 16'h7FFF, 16'h7FFF, 0);
    issue(2'b01, 0, 0, 0, 16'h7FFF, 16'h7FFF, 0);
    chk("mac_wrap", mr_out, 32'hBFFD_0003);
    chk("mac_wrap_mn", mul_mn, 1);
    chk("mac_wrap_mv", mul_mv, 1);
    issue(2'b11, 0, 0, 0, 16'h0, 16'h0, 0);

    // Back-to-back with the request never dropped and the bus scrambled while busy
    issue(2'b00, 0, 0, 0, 16'h0123, 16'h0456, 1);
    issue(2'b01, 1, 1, 1, 16'hC000, 16'h3FFF, 1);
    issue(2'b10, 1, 0, 0, 16'h8001, 16'h7FFF, 1);
    ps_mul_req = 1'b0;

    for (int i = 0; i < 10; i++) begin
      issue(2'($urandom_range(0, 2)), 1'($urandom), 1'($urandom), 1'($urandom),
            16'($urandom), 16'($urandom), 0);
    end
    issue(2'b11, 0, 0, 0, 16'h0, 16'h0, 0);

    issue(2'b00, 1, 0, 0, 16'h2468, 16'h4000, 0);
    chk("pre_reset_mr", mr_out, 32'h1234_0000);
    ps_mul_op = 2'b01; ps_mul_IbF = 1'b1; ps_mul_rndPrdt = 1'b0; ps_mul_sat = 1'b0;
    xb_dtx = 16'h4000; xb_dty = 16'h4000; ps_mul_req = 1'b1;
    @(negedge clk);
    ps_mul_req = 1'b0;
    reset = 1'b0;
    #1;
    chk("arst_mr", mr_out, 0);
    chk("arst_ready", mul_ready, 1);
    chk("arst_done", mul_done, 0);
    #2;
    reset = 1'b1;
    m_mr = '0;
    m_mv = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("no_done_after_rst", mul_done, 0);
    end
    issue(2'b00, 1, 0, 0, 16'h4000, 16'h4000, 0);
    chk("post_reset", mr_out, 32'h2000_0000);
    issue(2'b10, 1, 1, 0, 16'h0003, 16'h4000, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mul_seq.md
# mul_seq

Sequencing controller for the multiplier/rounding datapath. It accepts one multiply-class instruction at a time over a valid/ready handshake and registers the operands. It then steps the operation through a multiply stage and an accumulate/round stage, and owns the 2*SIZE-bit MR result register and its status flags. Sits between the instruction decode (ps_*) and data crossbar (xb_*) on one side and the register-file/status writeback on the other.

## Interface
- SIZE, 16, operand width; MR and product are 2*SIZE bits
- clk  in  1  clock, rising-edge
- reset  in  1  asynchronous, active-low
- ps_mul_req  in  1  instruction valid
- mul_ready  out  1  controller can accept (high only in IDLE)
- ps_mul_op  in  2  00 MUL (MR=P), 01 MAC (MR=MR+P), 10 MSUB (MR=MR-P), 11 CLR (MR=0, clear mv)
- ps_mul_IbF  in  1  1=fractional (signed Q-format), 0=signed integer
- ps_mul_rndPrdt  in  1  round result to upper SIZE bits (honoured only when IbF=1)
- ps_mul_sat  in  1  1=saturate on overflow, 0=wrap
- xb_dtx, xb_dty  in  SIZE each  signed operands
- mr_out  out  2*SIZE  MR register
- mul_done  out  1  one-cycle pulse, MR/flags just updated
- mul_mn  out  1  MR sign after last update
- mul_mv  out  1  sticky overflow

## Operation
- States: IDLE, MUL, ACC. Transitions:
  - IDLE→MUL on ps_mul_req & mul_ready.
  - MUL→ACC unconditionally.
  - ACC→IDLE unconditionally.
- Acceptance registers op, IbF, rndPrdt, sat, xb_dtx and xb_dty. Input changes after acceptance have no effect. Requests outside IDLE are ignored (mul_ready=0); no queueing.
- MUL state: the product register P is loaded with the signed SIZE×SIZE product, 2*SIZE bits.
  - IbF=1: P = product<<1.
  - Special case: dtx=dty=0x8000 (most-negative for SIZE=16) gives P=0x7FFF_FFFF and sets the MUL-overflow condition.
- ACC state: R is computed per op, then MR, mn and mv load on the ACC→IDLE edge.
  - MUL: R=P.
  - MAC: R=MR+P.
  - MSUB: R=MR−P.
  - Overflow is detected by two's-complement sign rule.
- Saturation: if overflow and sat=1, R saturates to 0x7FFF_FFFF (positive overflow) or 0x8000_0000 (negative). If sat=0, R wraps.
- Rounding (only when rndPrdt=1 and IbF=1) is applied to R after saturation. Let H = R[2S-1:S] and L = R[S-1:0].
  - R[S-1]=0: result {H, 0}.
  - R[S-1]=1 and R[S-2:0]≠0: result {H+1, 0}.
  - R[S-1]=1 and R[S-2:0]=0 (tie): result {H+R[S], 0}, i.e. round-half-even.
  - If the round increment overflows H (H=0x7FFF): with sat=1 the result is 0x7FFF_0000; with sat=0 it wraps to 0x8000_0000. Either way this is an overflow.
- mul_mv is set by any of the MUL special case, an add/sub overflow, or a round overflow. It stays set until CLR or reset.
- CLR: MR=0, mv=0, mn=0; operands ignored; same 3-state path.
- mul_mn = MR[2S-1] of the new value.

## Timing
- Request accepted at the edge ending cycle T. State is MUL in T+1 and ACC in T+2.
- IDLE again in T+3, with mul_done=1, mr_out/mn/mv updated and mul_ready=1.
- Next request can be accepted at the edge ending T+3: throughput one op per 3 cycles, latency 3.
- mul_done is registered, high exactly one cycle per op.
- Reset (asynchronous, any state including mid-operation):
  - state=IDLE, mul_ready=1.
  - mul_done=0, mr_out=0, mul_mn=0, mul_mv=0.
  - P and the captured operands are cleared.
  - The aborted op has no effect; no done pulse follows.
- mr_out, mn and mv hold their values in all cycles except the ACC→IDLE edge.

## Test plan
- Fractional MUL, 0x4000×0x4000, rnd=0 → mul_done at T+3, mr_out=0x2000_0000, mn=0, mv=0; mul_ready low in T+1 and T+2.
- Rounding, fractional MUL with rnd=1:
  - 0x0003×0x4000 (tie, odd H) → 0x0002_0000.
  - 0x0001×0x4000 (tie, even H) → 0x0000_0000.
  - 0x0003×0x2001 → 0x0001_0000.
- Fractional MUL 0x8000×0x8000 → mr_out=0x7FFF_FFFF, mv=1; a following CLR → mr_out=0, mv=0.
- Integer saturation: MUL 0x7FFF×0x7FFF (0x3FFF_0001), then MAC twice.
  - sat=1: results 0x7FFE_0002, then 0x7FFF_FFFF with mv=1.
  - Same sequence with sat=0: 0xBFFD_0003, mn=1, mv=1.
- Handshake: ps_mul_req held high continuously → ops accepted every 3 cycles. Requests in MUL/ACC cycles are dropped. Operand changes during MUL do not alter the result.
- Reset pulsed low during the MUL state of a MAC with MR=0x1234_0000 → immediately mr_out=0, mul_ready=1; no mul_done pulse; the next MUL completes normally in 3 cycles.
